// File: rtl/divisor_radix_param.sv
// Multicycle restoring integer divider, signed/unsigned per operation, BITS_CICLO quotient bits per cycle.
// Latency: tamanyo/BITS_CICLO + 2 edges from accepted Start to Done; 2 edges for divide by zero.
// Backpressure: none; Start is ignored while Busy, and Start in the Done cycle is accepted.
module divisor_radix_param #(
  parameter int tamanyo    = 32,
  parameter int BITS_CICLO = 1
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Start,
  input  logic               Signo,
  input  logic [tamanyo-1:0] Num,
  input  logic [tamanyo-1:0] Den,
  output logic [tamanyo-1:0] Coc,
  output logic [tamanyo-1:0] Res,
  output logic               Done,
  output logic               Busy,
  output logic               DivCero,
  output logic               Desb
);

  localparam int W  = tamanyo;
  localparam int N  = tamanyo / BITS_CICLO;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] CONT_INIT = CW'(N - 1);

  // Refuse to elaborate with an unsupported geometry.
  if ((BITS_CICLO != 1 && BITS_CICLO != 2 && BITS_CICLO != 4) ||
      (tamanyo < 4) || ((tamanyo % 2) != 0) ||
      ((tamanyo % BITS_CICLO) != 0)) begin : g_bad_params
    $error("divisor_radix_param: unsupported tamanyo/BITS_CICLO combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t         state_q;
  logic           signo_q;
  logic           sn_q;      // dividend was negative (signed mode only)
  logic           sd_q;      // divisor was negative (signed mode only)
  logic           zero_q;    // divisor was zero
  logic           ovf_q;     // MIN / -1 in signed mode
  logic [W-1:0]   q_q;       // dividend magnitude shifting into quotient
  logic [W-1:0]   m_q;       // divisor magnitude
  logic [W-1:0]   accu_q;    // partial remainder
  logic [CW-1:0]  cont_q;

  logic [W-1:0]   q_d;
  logic [W-1:0]   accu_d;
  logic [W:0]     step_sh;
  logic [W-1:0]   step_a;
  logic [W-1:0]   step_q;

  // Operand magnitudes and sign capture at Start.
  logic           num_neg;
  logic           den_neg;
  logic [W-1:0]   num_mag;
  logic [W-1:0]   den_mag;
  logic           ovf_in;

  assign num_neg = Signo & Num[W-1];
  assign den_neg = Signo & Den[W-1];
  assign num_mag = num_neg ? -Num : Num;
  assign den_mag = den_neg ? -Den : Den;
  assign ovf_in  = Signo && (Num == MIN_VAL) && (Den == {W{1'b1}});

  // BITS_CICLO chained restoring steps; W+1-bit compare keeps the shifted carry exact.
  always_comb begin
    step_a  = accu_q;
    step_q  = q_q;
    step_sh = '0;
    for (int i = 0; i < BITS_CICLO; i++) begin
      step_sh = {step_a, step_q[W-1]};
      step_q  = {step_q[W-2:0], 1'b0};
      if (step_sh >= {1'b0, m_q}) begin
        step_sh   = step_sh - {1'b0, m_q};
        step_q[0] = 1'b1;
      end
      step_a = step_sh[W-1:0];
    end
    accu_d = step_a;
    q_d    = step_q;
  end

  // Control FSM with registered results, flags and handshake outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      signo_q <= 1'b0;
      sn_q    <= 1'b0;
      sd_q    <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      q_q     <= '0;
      m_q     <= '0;
      accu_q  <= '0;
      cont_q  <= '0;
      Coc     <= '0;
      Res     <= '0;
      Done    <= 1'b0;
      Busy    <= 1'b0;
      DivCero <= 1'b0;
      Desb    <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (Start) begin
            signo_q <= Signo;
            sn_q    <= num_neg;
            sd_q    <= den_neg;
            zero_q  <= (Den == '0);
            ovf_q   <= ovf_in;
            q_q     <= num_mag;
            m_q     <= den_mag;
            accu_q  <= '0;
            cont_q  <= CONT_INIT;
            Busy    <= 1'b1;
            state_q <= (Den == '0) ? FIX : CALC;
          end
        end
        CALC: begin
          q_q    <= q_d;
          accu_q <= accu_d;
          if (cont_q == '0) begin
            state_q <= FIX;
          end else begin
            cont_q <= cont_q - 1'b1;
          end
        end
        FIX: begin
          if (zero_q) begin
            // q_q still holds |Num|; re-applying the sign restores Num as sampled.
            Coc     <= {W{1'b1}};
            Res     <= sn_q ? -q_q : q_q;
            DivCero <= 1'b1;
            Desb    <= 1'b0;
          end else begin
            // Truncating division: remainder follows the dividend's sign.
            Coc     <= (signo_q & (sn_q ^ sd_q)) ? -q_q : q_q;
            Res     <= (signo_q & sn_q) ? -accu_q : accu_q;
            DivCero <= 1'b0;
            Desb    <= ovf_q;
          end
          Done    <= 1'b1;
          Busy    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          Busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_radix_param.sv
// Bench for divisor_radix_param: one radix-2 and one radix-16 instance, arithmetic reference model.
// Latency expectations derive from N = 32/BITS_CICLO; outputs sampled on the falling edge.
// Start is driven shortly after the falling edge; the bench never stalls the DUT.
module tb_divisor_radix_param;

  typedef struct {
    int          st;
    int          due;
    logic [31:0] coc;
    logic [31:0] res;
    logic        dz;
    logic        ov;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start [2];
  logic        signo [2];
  logic [31:0] num   [2];
  logic [31:0] den   [2];
  logic [31:0] coc   [2];
  logic [31:0] res   [2];
  logic        done  [2];
  logic        busy  [2];
  logic        dz    [2];
  logic        ov    [2];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit chk_en   = 0;

  exp_t eq0[$];
  exp_t eq1[$];
  exp_t last0;
  exp_t last1;

  divisor_radix_param #(.tamanyo(32), .BITS_CICLO(1)) u_r1 (
    .CLK(clk), .RST(rst), .Start(start[0]), .Signo(signo[0]),
    .Num(num[0]), .Den(den[0]), .Coc(coc[0]), .Res(res[0]),
    .Done(done[0]), .Busy(busy[0]), .DivCero(dz[0]), .Desb(ov[0])
  );

  divisor_radix_param #(.tamanyo(32), .BITS_CICLO(4)) u_r4 (
    .CLK(clk), .RST(rst), .Start(start[1]), .Signo(signo[1]),
    .Num(num[1]), .Den(den[1]), .Coc(coc[1]), .Res(res[1]),
    .Done(done[1]), .Busy(busy[1]), .DivCero(dz[1]), .Desb(ov[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%h want=%h", nm, k, cyc, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic, SV '/' and '%' truncate toward zero.
  function automatic exp_t model(input bit s, input logic [31:0] n, input logic [31:0] d);
    exp_t e;
    logic signed [63:0] sn, sd, qq, rr;
    e.st = 0; e.due = 0; e.dz = 1'b0; e.ov = 1'b0;
    if (d == 32'd0) begin
      e.coc = 32'hFFFF_FFFF;
      e.res = n;
      e.dz  = 1'b1;
    end else if (s) begin
      sn = 64'($signed(n));
      sd = 64'($signed(d));
      qq = sn / sd;
      rr = sn % sd;
      e.coc = qq[31:0];
      e.res = rr[31:0];
      e.ov  = (n == 32'h8000_0000) && (d == 32'hFFFF_FFFF);
    end else begin
      e.coc = n / d;
      e.res = n % d;
    end
    return e;
  endfunction

  function automatic int lat(input int k, input logic [31:0] d);
    if (d == 32'd0) return 2;
    return (k == 0) ? 34 : 10;
  endfunction

  // Per-cycle comparison of one instance against the queued expectations.
  task automatic check_one(input int k);
    exp_t e;
    exp_t l;
    bit   have;
    bit   exp_done;
    bit   exp_busy;
    have = 1'b0;
    if (k == 0) begin
      have = (eq0.size() > 0);
      if (have) e = eq0[0];
      l = last0;
    end else begin
      have = (eq1.size() > 0);
      if (have) e = eq1[0];
      l = last1;
    end
    exp_done = have && (e.due == cyc);
    exp_busy = have && (cyc >= e.st) && (cyc < e.due);
    if (exp_done) begin
      l = e;
      if (k == 0) begin last0 = e; void'(eq0.pop_front()); end
      else begin last1 = e; void'(eq1.pop_front()); end
    end
    chk("done", k, {31'd0, done[k]}, {31'd0, exp_done});
    chk("busy", k, {31'd0, busy[k]}, {31'd0, exp_busy});
    chk("coc", k, coc[k], l.coc);
    chk("res", k, res[k], l.res);
    chk("divcero", k, {31'd0, dz[k]}, {31'd0, l.dz});
    chk("desb", k, {31'd0, ov[k]}, {31'd0, l.ov});
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_one(0);
      check_one(1);
    end
  end

  // Called just after a falling edge; drives Start for one cycle.
  task automatic issue(input int k, input bit s, input logic [31:0] n, input logic [31:0] d, input bit push);
    exp_t e;
    start[k] = 1'b1;
    signo[k] = s;
    num[k]   = n;
    den[k]   = d;
    if (push) begin
      e     = model(s, n, d);
      e.st  = cyc + 1;
      e.due = cyc + lat(k, d);
      if (k == 0) eq0.push_back(e); else eq1.push_back(e);
    end
    @(negedge clk); #1;
    start[k] = 1'b0;
    num[k]   = $urandom;
    den[k]   = $urandom;
    signo[k] = ~s;
  endtask

  // Returns in the Done cycle of the last queued operation.
  task automatic wait_done(input int k);
    int n;
    n = 0;
    while (((k == 0) ? eq0.size() : eq1.size()) > 0) begin
      @(negedge clk); #1;
      n++;
      if (n > 200) begin
        checks++;
        failures++;
        $display("FAIL timeout dut%0d cyc=%0d got=no_done want=done", k, cyc);
        if (k == 0) eq0.delete(); else eq1.delete();
      end
    end
  endtask

  task automatic pin(input string nm, input bit s, input logic [31:0] n, input logic [31:0] d,
                     input logic [31:0] c, input logic [31:0] r, input logic z, input logic o);
    exp_t e;
    e = model(s, n, d);
    chk({nm, "_coc"}, 9, e.coc, c);
    chk({nm, "_res"}, 9, e.res, r);
    chk({nm, "_dz"}, 9, {31'd0, e.dz}, {31'd0, z});
    chk({nm, "_ov"}, 9, {31'd0, e.ov}, {31'd0, o});
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; signo[k] = 1'b0; num[k] = '0; den[k] = '0;
    end
    last0 = model(0, 0, 1); last0.coc = '0; last0.res = '0;
    last1 = last0;

    // Hand-computed pins of the reference model.
    pin("m_100_7",   1, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
    pin("m_n100_7",  1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
    pin("m_100_n7",  1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
    pin("m_uff_16",  0, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0);
    pin("m_sff_16",  1, 32'hFFFF_FFFF, 32'h10, 32'h0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    pin("m_zero",    1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b0);
    pin("m_ovf",     1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b1);
    pin("m_uovf",    0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #1;

    // Radix-2 instance: signed cases issued back-to-back in each Done cycle.
    issue(0, 1, 32'd100, 32'd7, 1);            wait_done(0);
    issue(0, 1, 32'hFFFF_FF9C, 32'd7, 1);      wait_done(0);
    issue(0, 1, 32'd100, 32'hFFFF_FFF9, 1);    wait_done(0);
    issue(0, 1, 32'd1234, 32'd0, 1);           wait_done(0);
    issue(0, 0, 32'd1234, 32'd0, 1);           wait_done(0);
    issue(0, 0, 32'd1000, 32'd33, 1);          wait_done(0);
    issue(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done(0);
    issue(0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done(0);
    issue(0, 1, 32'h8000_0000, 32'h8000_0000, 1); wait_done(0);

    // Start while busy must be ignored.
    issue(0, 0, 32'd5000, 32'd3, 1);
    repeat (3) @(negedge clk); #1;
    issue(0, 1, 32'd77, 32'd5, 0);
    wait_done(0);

    // Radix-16 instance.
    issue(1, 0, 32'hFFFF_FFFF, 32'h10, 1);     wait_done(1);
    issue(1, 1, 32'hFFFF_FFFF, 32'h10, 1);     wait_done(1);
    issue(1, 1, 32'd1234, 32'd0, 1);           wait_done(1);
    issue(1, 1, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 1); wait_done(1);
    issue(1, 0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1); wait_done(1);
    issue(1, 0, 32'd7, 32'h8000_0000, 1);      wait_done(1);
    issue(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 1); wait_done(1);
    repeat (2) @(negedge clk); #1;

    // Reset in the fifth CALC cycle aborts without Done and zeroes every output.
    issue(0, 0, 32'd999, 32'd10, 1);
    repeat (4) @(negedge clk); #1;
    rst = 1'b1;
    eq0.delete();
    eq1.delete();
    last0.coc = '0; last0.res = '0; last0.dz = 1'b0; last0.ov = 1'b0;
    last1 = last0;
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (40) @(negedge clk); #1;
    issue(0, 1, 32'hFFFF_FF9C, 32'd7, 1);      wait_done(0);
    repeat (3) @(negedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
